// File: rtl/calc_cmd_sequencer.sv
// Front-end for the 8-bit accumulator calculator: debounces the go button, queues
// {op, operand} on each press and issues them one at a time to the datapath.
`timescale 1ns/1ps

module calc_cmd_sequencer #(
  parameter logic [23:0] DEBOUNCE_CYCLES = 24'd10_000_000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          btn_go,
  input  logic [1:0]                    op_sel,
  input  logic [7:0]                    operand,
  input  logic                          run,
  input  logic                          flush,
  input  logic [7:0]                    dp_result,
  output logic                          exec_en,
  output logic [1:0]                    exec_op,
  output logic [7:0]                    exec_operand,
  output logic [7:0]                    result,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   queue_count,
  output logic                          overflow_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] operand;
  } cmd_t;

  logic              sync1_q, sync2_q;
  logic              db_q, db_d;
  logic [23:0]       db_cnt_q, db_cnt_d;
  logic              push_ev, push_req, push_ok, pop;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  cmd_t              mem_q [FIFO_DEPTH];
  cmd_t              head;
  cmd_t              exec_cmd_q;
  logic [7:0]        result_q;
  state_t            state_q, state_d;
  logic              load_cmd;

  // NOTE: non-blocking assignments make sync2_q take the old sync1_q, giving a true two-stage shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn_go;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q >= DEBOUNCE_CYCLES - 24'd1) begin
        db_d = sync2_q;
      end else if (db_cnt_q != '1) begin
        db_cnt_d = db_cnt_q + 24'd1;
      end else begin
        db_cnt_d = db_cnt_q;
      end
    end
  end

  // Press event fires in the cycle the debounced level commits its rise.
  assign push_ev  = db_d & ~db_q;
  assign push_req = push_ev & ~flush;
  assign pop      = (state_q == ST_ISSUE) & ~flush;
  assign push_ok  = push_req & ((count_q != FULL_CNT) | pop);
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push_ok) count_q <= count_q - CNT_W'(1);
      if (push_req && !push_ok) overflow_q <= 1'b1;
    end
  end

  // NOTE: queue storage has no reset; an entry is only read after the pointers say it was written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= '{op: op_sel, operand: operand};
  end

  always_comb begin
    state_d  = state_q;
    load_cmd = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (count_q != '0 && run) begin
            state_d  = ST_ISSUE;
            load_cmd = 1'b1;
          end
        end
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      exec_cmd_q <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_cmd) exec_cmd_q <= head;
      // The datapath settled at the close of ISSUE, so WAIT sees the new accumulator.
      if (state_q == ST_WAIT && !flush) result_q <= dp_result;
    end
  end

  assign exec_en      = (state_q == ST_ISSUE) & ~flush;
  assign exec_op      = exec_cmd_q.op;
  assign exec_operand = exec_cmd_q.operand;
  assign result       = result_q;
  assign busy         = (state_q != ST_IDLE) | (count_q != '0);
  assign queue_count  = count_q;
  assign overflow_err = overflow_q;

endmodule
